// File: rtl/Cache_struct.sv
// Shared cache types: MESI line state, set layout, bus opcodes and
// the miss-handler FSM state encoding.
package Cache_struct;

   localparam int WAYS = 8;
   localparam int TAG  = 18;

   typedef enum logic [1:0] {M = 2'd0, E = 2'd1, S = 2'd2, I = 2'd3} mesi_t;

   typedef struct packed {
      logic [TAG-1:0] tag;
      mesi_t          mesi;
   } line_t;

   typedef line_t [WAYS-1:0] sets_nway_t;

   typedef enum logic [1:0] {READ = 2'd0, RWIM = 2'd1, INVALIDATE = 2'd2, WRITEBACK = 2'd3} bus_op_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DECIDE = 3'd1,
      ST_INV    = 3'd2,
      ST_WB     = 3'd3,
      ST_FILL   = 3'd4,
      ST_UPDATE = 3'd5
   } state_t;

endpackage

// File: rtl/plru_tree.sv
// Combinational 8-way tree pseudo-LRU. Node n has children 2n+1/2n+2,
// leaves are ways 0..7 left to right, a 0 bit points left.
module plru_tree (
   input  logic [6:0] i_bits,
   input  logic [2:0] i_way,
   output logic [2:0] o_victim,
   output logic [6:0] o_bits
);

   logic [2:0] w_n1;
   logic [2:0] w_n2;
   logic [2:0] w_u1;
   logic [2:0] w_u2;

   // Victim walk: follow the bit at each level from the root down.
   always_comb begin
      o_victim[2] = i_bits[0];
      w_n1        = 3'd1 + {2'b00, i_bits[0]};
      o_victim[1] = i_bits[w_n1];
      w_n2        = 3'd3 + {1'b0, o_victim[2], o_victim[1]};
      o_victim[0] = i_bits[w_n2];
   end

   // Access update: every node on the way's path points to the other side.
   always_comb begin
      o_bits       = i_bits;
      w_u1         = 3'd1 + {2'b00, i_way[2]};
      w_u2         = 3'd3 + {1'b0, i_way[2:1]};
      o_bits[0]    = ~i_way[2];
      o_bits[w_u1] = ~i_way[1];
      o_bits[w_u2] = ~i_way[0];
   end

endmodule

// File: rtl/cache_miss_handler.sv
// Cache miss handler: completes one processor read/write per request,
// updating MESI/PLRU on hits and doing victim writeback + fill on misses.
// Optional statistics counters are enabled with the CACHE_STATS_EN macro.
module cache_miss_handler
   import Cache_struct::*;
#(
   parameter int WAYS_REP = 3,
   parameter int INDEX    = 14,
   parameter int CNT_W    = 32
) (
   input  logic                   clk,
   input  logic                   rstb,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_write,
   input  logic [TAG-1:0]         req_tag,
   input  logic [INDEX-1:0]       req_index,
   input  sets_nway_t             sets,
   input  logic [6:0]             plru_in,
   input  logic                   hit,
   input  logic [WAYS_REP-1:0]    hit_way,
   output logic                   bus_valid,
   output bus_op_t                bus_op,
   output logic [TAG+INDEX-1:0]   bus_addr,
   input  logic                   bus_ack,
   input  logic                   bus_shared,
   output logic                   upd_valid,
   output logic [WAYS_REP-1:0]    upd_way,
   output logic [TAG-1:0]         upd_tag,
   output mesi_t                  upd_mesi,
   output logic [6:0]             plru_out,
   output logic                   done
`ifdef CACHE_STATS_EN
   ,
   output logic [CNT_W-1:0]       hit_cnt,
   output logic [CNT_W-1:0]       miss_cnt,
   output logic [CNT_W-1:0]       wb_cnt
`endif
);

   state_t                r_state;
   state_t                w_next;
   logic                  r_write;
   logic [TAG-1:0]        r_tag;
   logic [INDEX-1:0]      r_index;
   logic [WAYS_REP-1:0]   r_way;
   logic [TAG-1:0]        r_victim_tag;
   mesi_t                 r_mesi;
   logic [6:0]            r_plru;
   logic                  r_bus_valid;
   logic                  w_ack;
   logic                  w_any_inv;
   logic [WAYS_REP-1:0]   w_inv_way;
   logic [WAYS_REP-1:0]   w_plru_victim;
   logic [WAYS_REP-1:0]   w_way;
   logic [6:0]            w_plru_upd;
   logic                  w_bus_state;

   plru_tree u_plru (
      .i_bits   (plru_in),
      .i_way    (w_way),
      .o_victim (w_plru_victim),
      .o_bits   (w_plru_upd)
   );

   // Lowest-numbered invalid way, scanned high to low so the lowest wins.
   always_comb begin
      w_any_inv = 1'b0;
      w_inv_way = '0;
      for (int k = WAYS - 1; k >= 0; k--) begin
         if (sets[k].mesi == I) begin
            w_any_inv = 1'b1;
            w_inv_way = k[WAYS_REP-1:0];
         end
      end
   end

   // Way being serviced: hit way, else first invalid, else PLRU victim.
   always_comb begin
      w_way = hit ? hit_way : (w_any_inv ? w_inv_way : w_plru_victim);
   end

   // An ack only counts once our request is visible on the bus.
   assign w_bus_state = (r_state == ST_INV) || (r_state == ST_WB) || (r_state == ST_FILL);
   assign w_ack       = bus_ack && r_bus_valid && w_bus_state;

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   if (req_valid) w_next = ST_DECIDE;
         ST_DECIDE: begin
            if (hit) begin
               if (r_write && (sets[hit_way].mesi == S)) w_next = ST_INV;
               else                                      w_next = ST_UPDATE;
            end else if (sets[w_way].mesi == M) begin
               w_next = ST_WB;
            end else begin
               w_next = ST_FILL;
            end
         end
         ST_INV:    if (w_ack) w_next = ST_UPDATE;
         ST_WB:     if (w_ack) w_next = ST_FILL;
         ST_FILL:   if (w_ack) w_next = ST_UPDATE;
         ST_UPDATE: w_next = ST_IDLE;
         default:   w_next = ST_IDLE;
      endcase
   end

   // Request latch, decision capture and fill result.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         r_write      <= 1'b0;
         r_tag        <= '0;
         r_index      <= '0;
         r_way        <= '0;
         r_victim_tag <= '0;
         r_mesi       <= M;
         r_plru       <= '0;
      end else begin
         if ((r_state == ST_IDLE) && req_valid) begin
            r_write <= req_write;
            r_tag   <= req_tag;
            r_index <= req_index;
         end
         if (r_state == ST_DECIDE) begin
            r_way        <= w_way;
            r_victim_tag <= sets[w_way].tag;
            r_plru       <= w_plru_upd;
            r_mesi       <= r_write ? M : (hit ? sets[hit_way].mesi : E);
         end
         if ((r_state == ST_FILL) && w_ack && !r_write) begin
            r_mesi <= bus_shared ? S : E;
         end
      end
   end

   // Bus request rises one cycle into a bus state and drops after the ack.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb)            r_bus_valid <= 1'b0;
      else if (w_ack)       r_bus_valid <= 1'b0;
      else                  r_bus_valid <= w_bus_state;
   end

   // Bus opcode/address and commit outputs, zero outside their states.
   always_comb begin
      bus_op   = READ;
      bus_addr = '0;
      case (r_state)
         ST_INV:  begin bus_op = INVALIDATE; bus_addr = {r_tag, r_index}; end
         ST_WB:   begin bus_op = WRITEBACK;  bus_addr = {r_victim_tag, r_index}; end
         ST_FILL: begin bus_op = r_write ? RWIM : READ; bus_addr = {r_tag, r_index}; end
         default: begin bus_op = READ; bus_addr = '0; end
      endcase
      req_ready = (r_state == ST_IDLE);
      bus_valid = r_bus_valid;
      upd_valid = (r_state == ST_UPDATE);
      done      = (r_state == ST_UPDATE);
      upd_way   = upd_valid ? r_way : '0;
      upd_tag   = upd_valid ? r_tag : '0;
      upd_mesi  = upd_valid ? r_mesi : M;
      plru_out  = upd_valid ? r_plru : '0;
   end

`ifdef CACHE_STATS_EN
   // Saturating hit/miss/writeback counters.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
         wb_cnt   <= '0;
      end else begin
         if ((r_state == ST_DECIDE) && hit && (hit_cnt != '1))   hit_cnt  <= hit_cnt + 1'b1;
         if ((r_state == ST_DECIDE) && !hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
         if ((r_state == ST_WB) && w_ack && (wb_cnt != '1))      wb_cnt   <= wb_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_cache_miss_handler.sv
// Directed bench for cache_miss_handler. Inputs change and outputs are
// checked on the falling clock edge; the DUT acts on the rising edge.
module tb_cache_miss_handler;
   import Cache_struct::*;

   localparam int WR = 3;
   localparam int IX = 14;
   localparam int CW = 32;

   logic              clk = 1'b0;
   logic              rstb;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [TAG-1:0]    req_tag;
   logic [IX-1:0]     req_index;
   sets_nway_t        sets;
   logic [6:0]        plru_in;
   logic              hit;
   logic [WR-1:0]     hit_way;
   logic              bus_valid;
   bus_op_t           bus_op;
   logic [TAG+IX-1:0] bus_addr;
   logic              bus_ack;
   logic              bus_shared;
   logic              upd_valid;
   logic [WR-1:0]     upd_way;
   logic [TAG-1:0]    upd_tag;
   mesi_t             upd_mesi;
   logic [6:0]        plru_out;
   logic              done;
`ifdef CACHE_STATS_EN
   logic [CW-1:0]     hit_cnt;
   logic [CW-1:0]     miss_cnt;
   logic [CW-1:0]     wb_cnt;
`endif

   int checks = 0;
   int errors = 0;

   cache_miss_handler #(.WAYS_REP(WR), .INDEX(IX), .CNT_W(CW)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_tag    (req_tag),
      .req_index  (req_index),
      .sets       (sets),
      .plru_in    (plru_in),
      .hit        (hit),
      .hit_way    (hit_way),
      .bus_valid  (bus_valid),
      .bus_op     (bus_op),
      .bus_addr   (bus_addr),
      .bus_ack    (bus_ack),
      .bus_shared (bus_shared),
      .upd_valid  (upd_valid),
      .upd_way    (upd_way),
      .upd_tag    (upd_tag),
      .upd_mesi   (upd_mesi),
      .plru_out   (plru_out),
      .done       (done)
`ifdef CACHE_STATS_EN
      ,
      .hit_cnt    (hit_cnt),
      .miss_cnt   (miss_cnt),
      .wb_cnt     (wb_cnt)
`endif
   );

   // Clock: 10 ns period.
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic fill_sets(input mesi_t m);
      for (int k = 0; k < WAYS; k++) begin
         sets[k].tag  = 18'h00100 + 18'(k);
         sets[k].mesi = m;
      end
   endtask

   task automatic start_req(input logic wr, input logic [TAG-1:0] t, input logic [IX-1:0] ix);
      req_valid = 1'b1;
      req_write = wr;
      req_tag   = t;
      req_index = ix;
   endtask

   initial begin
      rstb = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_tag = '0; req_index = '0;
      plru_in = '0; hit = 1'b0; hit_way = '0; bus_ack = 1'b0; bus_shared = 1'b0;
      fill_sets(I);
      cyc(); cyc();

      // Reset values
      chk("rst_req_ready", req_ready, 1);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_upd_valid", upd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_bus_op", bus_op, READ);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_plru_out", plru_out, 0);
      rstb = 1'b1;
      cyc();

      // Read hit, way 5 in E, plru 0: path bits 0=0, 2=1, 5=0
      fill_sets(S); sets[5].mesi = E; hit = 1'b1; hit_way = 3'd5; plru_in = 7'b0000000;
      start_req(1'b0, 18'h00ABC, 14'h0123);
      cyc(); req_valid = 1'b0;
      chk("rh_decide_ready", req_ready, 0);
      chk("rh_decide_done", done, 0);
      cyc();
      chk("rh_done", done, 1);
      chk("rh_upd_valid", upd_valid, 1);
      chk("rh_upd_way", upd_way, 5);
      chk("rh_upd_mesi", upd_mesi, E);
      chk("rh_upd_tag", upd_tag, 18'h00ABC);
      chk("rh_plru", plru_out, 7'b0000100);
      chk("rh_bus_valid", bus_valid, 0);
      cyc();
      chk("rh_idle_done", done, 0);
      chk("rh_idle_ready", req_ready, 1);
      cyc();

      // Read miss, all S, plru 0 -> victim 0; ack before the bus request is ignored
      fill_sets(S); hit = 1'b0; hit_way = 3'd0; plru_in = 7'b0000000; bus_shared = 1'b0;
      start_req(1'b0, 18'h2A5A5, 14'h3F0F);
      bus_ack = 1'b1;
      cyc(); req_valid = 1'b0;
      chk("rm_decide_bv", bus_valid, 0);
      cyc();
      chk("rm_fill_bv_low", bus_valid, 0);
      chk("rm_fill_no_done", done, 0);
      bus_ack = 1'b0;
      cyc();
      chk("rm_bv_high", bus_valid, 1);
      chk("rm_op", bus_op, READ);
      chk("rm_addr", bus_addr, {18'h2A5A5, 14'h3F0F});
      cyc();
      chk("rm_bv_hold", bus_valid, 1);
      chk("rm_addr_hold", bus_addr, {18'h2A5A5, 14'h3F0F});
      bus_ack = 1'b1;
      cyc(); bus_ack = 1'b0;
      chk("rm_done", done, 1);
      chk("rm_upd_way", upd_way, 0);
      chk("rm_upd_mesi", upd_mesi, E);
      chk("rm_plru", plru_out, 7'b0001011);
      chk("rm_bv_fall", bus_valid, 0);
      cyc(); cyc();

      // Write miss, way 3 invalid, rest M, plru all ones -> invalid way wins
      fill_sets(M); sets[3].mesi = I; hit = 1'b0; plru_in = 7'b1111111;
      start_req(1'b1, 18'h12345, 14'h0042);
      cyc(); req_valid = 1'b0;
      cyc();
      chk("wm_bv_low", bus_valid, 0);
      cyc();
      chk("wm_bv_high", bus_valid, 1);
      chk("wm_op", bus_op, RWIM);
      chk("wm_addr", bus_addr, {18'h12345, 14'h0042});
      bus_ack = 1'b1;
      cyc(); bus_ack = 1'b0;
      chk("wm_done", done, 1);
      chk("wm_upd_way", upd_way, 3);
      chk("wm_upd_mesi", upd_mesi, M);
      chk("wm_plru", plru_out, 7'b1101101);
      cyc(); cyc();

      // Read miss, all M, plru all ones -> writeback way 7, then shared fill
      fill_sets(M); hit = 1'b0; plru_in = 7'b1111111;
      start_req(1'b0, 18'h3C3C3, 14'h1111);
      cyc(); req_valid = 1'b0;
      cyc();
      chk("wb_bv_low", bus_valid, 0);
      cyc();
      chk("wb_bv_high", bus_valid, 1);
      chk("wb_op", bus_op, WRITEBACK);
      chk("wb_addr", bus_addr, {18'h00107, 14'h1111});
      bus_ack = 1'b1;
      cyc(); bus_ack = 1'b0;
      chk("wb_gap_bv", bus_valid, 0);
      chk("wb_gap_op", bus_op, READ);
      chk("wb_gap_done", done, 0);
      cyc();
      chk("wbf_bv_high", bus_valid, 1);
      chk("wbf_op", bus_op, READ);
      chk("wbf_addr", bus_addr, {18'h3C3C3, 14'h1111});
      bus_ack = 1'b1; bus_shared = 1'b1;
      cyc(); bus_ack = 1'b0; bus_shared = 1'b0;
      chk("wbf_done", done, 1);
      chk("wbf_upd_way", upd_way, 7);
      chk("wbf_upd_mesi", upd_mesi, S);
      chk("wbf_plru", plru_out, 7'b0111010);
      cyc(); cyc();

      // Write hit on S way 2 -> invalidate then M
      fill_sets(E); sets[2].mesi = S; hit = 1'b1; hit_way = 3'd2; plru_in = 7'b1111111;
      start_req(1'b1, 18'h00102, 14'h2222);
      cyc(); req_valid = 1'b0;
      cyc();
      chk("inv_bv_low", bus_valid, 0);
      chk("inv_no_done", done, 0);
      cyc();
      chk("inv_bv_high", bus_valid, 1);
      chk("inv_op", bus_op, INVALIDATE);
      chk("inv_addr", bus_addr, {18'h00102, 14'h2222});
      bus_ack = 1'b1;
      cyc(); bus_ack = 1'b0;
      chk("inv_done", done, 1);
      chk("inv_upd_way", upd_way, 2);
      chk("inv_upd_mesi", upd_mesi, M);
      chk("inv_plru", plru_out, 7'b1111101);
      cyc(); cyc();

      // Write hit on E way 6 -> no bus traffic, M at cycle 2
      fill_sets(E); hit = 1'b1; hit_way = 3'd6; plru_in = 7'b0000000;
      start_req(1'b1, 18'h00106, 14'h0006);
      cyc(); req_valid = 1'b0;
      cyc();
      chk("we_done", done, 1);
      chk("we_upd_mesi", upd_mesi, M);
      chk("we_plru", plru_out, 7'b1000000);
      chk("we_bv", bus_valid, 0);
      cyc();
`ifdef CACHE_STATS_EN
      chk("st_hit_cnt", hit_cnt, 3);
      chk("st_miss_cnt", miss_cnt, 3);
      chk("st_wb_cnt", wb_cnt, 1);
`endif
      cyc();

      // Reset while waiting for the fill ack
      fill_sets(S); hit = 1'b0; plru_in = 7'b0000000;
      start_req(1'b0, 18'h01234, 14'h0555);
      cyc(); req_valid = 1'b0;
      cyc(); cyc();
      chk("rf_bv_high", bus_valid, 1);
      rstb = 1'b0;
      #1;
      chk("rf_req_ready", req_ready, 1);
      chk("rf_bv", bus_valid, 0);
      chk("rf_done", done, 0);
      chk("rf_bus_op", bus_op, READ);
`ifdef CACHE_STATS_EN
      chk("rf_hit_cnt", hit_cnt, 0);
      chk("rf_miss_cnt", miss_cnt, 0);
      chk("rf_wb_cnt", wb_cnt, 0);
`endif
      cyc(); rstb = 1'b1;
      for (int c = 0; c < 4; c++) begin
         cyc();
         chk("rf_post_done", done, 0);
      end
      chk("rf_post_ready", req_ready, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
